// File: rtl/dual_ram_pkg.sv
// rtl/dual_ram_pkg.sv - shared widths and command/response types for the dual RAM front end
// Contents:
//    DEF_DATA_W / DEF_ADDR_W : default RAM word and address widths
//    cmd_t                   : one port's registered command (en, we, addr, wdata)
//    rsp_t                   : one port's response register (valid, rdata)
package dual_ram_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;

   typedef struct packed {
      logic                  en;
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic                  valid;
      logic [DEF_DATA_W-1:0] rdata;
   } rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with write-conflict serialisation
// Ports:
//    clk, rst_n : clock, asynchronous active-low reset
//    req[1:0]   : request vector (bit x = port x valid)
//    conflict   : at least one request is a write, so only one port may go
//    gnt[1:0]   : combinational grant vector
//    rr         : round-robin pointer, the port favoured on the next conflict
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       conflict,
   output logic [1:0] gnt,
   output logic       rr
);

   logic both_conflict;

   assign both_conflict = (req == 2'b11) && conflict;

   always_comb begin
      gnt = req;
      if (both_conflict) begin
         gnt = rr ? 2'b10 : 2'b01;
      end
   end

   // The pointer only moves when a conflict was actually resolved, so a
   // stream of parallel reads never disturbs the fairness order for writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr <= 1'b0;
      end else if (both_conflict) begin
         rr <= ~rr;
      end
   end

endmodule

// File: rtl/dual_ram_access_ctrl.sv
// rtl/dual_ram_access_ctrl.sv - two-client request/response front end driving a 16x8 dual-address RAM
// Ports:
//    clk, rst_n                      : clock, asynchronous active-low reset
//    reqX_valid/ready/we/addr/wdata  : client X request handshake (X = 0, 1)
//    rspX_valid/rdata                : client X one-cycle response, read data or echoed write data
//    ram_wr_en, ram_data_in          : RAM write enable and shared write data
//    ram_addr_X, ram_port_en_X       : RAM per-port address and enable
//    ram_data_out_X                  : RAM combinational read data
//    stall_cnt                       : saturating count of port-cycles with valid && !ready
module dual_ram_access_ctrl
   import dual_ram_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int STALL_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              ram_wr_en,
   output logic [DATA_W-1:0] ram_data_in,
   output logic [ADDR_W-1:0] ram_addr_0,
   output logic [ADDR_W-1:0] ram_addr_1,
   output logic              ram_port_en_0,
   output logic              ram_port_en_1,
   input  logic [DATA_W-1:0] ram_data_out_0,
   input  logic [DATA_W-1:0] ram_data_out_1,
   output logic [STALL_W-1:0] stall_cnt
);

   logic [1:0] gnt;
   logic       rr_ptr_unused;
   cmd_t       cmd0, cmd1;
   rsp_t       rsp0, rsp1;
   logic       wr0, wr1;

   // A write anywhere makes the pair a conflict: the RAM has one data_in and
   // writes every enabled port, so writes must go out alone.
   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      ({req1_valid, req0_valid}),
      .conflict (req0_we | req1_we),
      .gnt      (gnt),
      .rr       (rr_ptr_unused)
   );

   // Grants are combinational; gating with rst_n keeps ready low while the
   // block is held in reset even though clients are already requesting.
   assign req0_ready = gnt[0] & rst_n;
   assign req1_ready = gnt[1] & rst_n;

   // Ungranted ports load an all-zero command so idle RAM pins read as 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd0 <= '0;
         cmd1 <= '0;
      end else begin
         cmd0 <= req0_ready ? cmd_t'{1'b1, req0_we, req0_addr, req0_wdata} : '0;
         cmd1 <= req1_ready ? cmd_t'{1'b1, req1_we, req1_addr, req1_wdata} : '0;
      end
   end

   assign wr0           = cmd0.en & cmd0.we;
   assign wr1           = cmd1.en & cmd1.we;
   assign ram_wr_en     = wr0 | wr1;
   assign ram_port_en_0 = cmd0.en;
   assign ram_port_en_1 = cmd1.en;
   assign ram_addr_0    = cmd0.addr;
   assign ram_addr_1    = cmd1.addr;
   assign ram_data_in   = wr0 ? cmd0.wdata : (wr1 ? cmd1.wdata : '0);

   // Read data is sampled at the same edge the RAM would commit a write;
   // the stage never mixes reads with a write, so no read-during-write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0 <= '0;
         rsp1 <= '0;
      end else begin
         rsp0.valid <= cmd0.en;
         rsp1.valid <= cmd1.en;
         if (cmd0.en) begin
            rsp0.rdata <= cmd0.we ? cmd0.wdata : ram_data_out_0;
         end
         if (cmd1.en) begin
            rsp1.rdata <= cmd1.we ? cmd1.wdata : ram_data_out_1;
         end
      end
   end

   assign rsp0_valid = rsp0.valid;
   assign rsp0_rdata = rsp0.rdata;
   assign rsp1_valid = rsp1.valid;
   assign rsp1_rdata = rsp1.rdata;

   // One extra sum bit detects overflow so the counter pins at all-ones.
   logic [1:0]       stall_inc;
   logic [STALL_W:0] stall_sum;

   assign stall_inc = {1'b0, req0_valid & ~req0_ready} + {1'b0, req1_valid & ~req1_ready};
   assign stall_sum = {1'b0, stall_cnt} + {{(STALL_W-1){1'b0}}, stall_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_sum[STALL_W] ? '1 : stall_sum[STALL_W-1:0];
      end
   end

endmodule

// File: tb/tb_dual_ram_access_ctrl.sv
// tb/tb_dual_ram_access_ctrl.sv - scoreboard bench for dual_ram_access_ctrl
module tb_dual_ram_access_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_ready, req0_we;
   logic [3:0] req0_addr;
   logic [7:0] req0_wdata;
   logic       rsp0_valid;
   logic [7:0] rsp0_rdata;
   logic       req1_valid, req1_ready, req1_we;
   logic [3:0] req1_addr;
   logic [7:0] req1_wdata;
   logic       rsp1_valid;
   logic [7:0] rsp1_rdata;
   logic       ram_wr_en;
   logic [7:0] ram_data_in;
   logic [3:0] ram_addr_0, ram_addr_1;
   logic       ram_port_en_0, ram_port_en_1;
   logic [7:0] ram_data_out_0, ram_data_out_1;
   logic [7:0] stall_cnt;

   always #5 clk = ~clk;

   dual_ram_access_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req0_valid     (req0_valid),
      .req0_ready     (req0_ready),
      .req0_we        (req0_we),
      .req0_addr      (req0_addr),
      .req0_wdata     (req0_wdata),
      .rsp0_valid     (rsp0_valid),
      .rsp0_rdata     (rsp0_rdata),
      .req1_valid     (req1_valid),
      .req1_ready     (req1_ready),
      .req1_we        (req1_we),
      .req1_addr      (req1_addr),
      .req1_wdata     (req1_wdata),
      .rsp1_valid     (rsp1_valid),
      .rsp1_rdata     (rsp1_rdata),
      .ram_wr_en      (ram_wr_en),
      .ram_data_in    (ram_data_in),
      .ram_addr_0     (ram_addr_0),
      .ram_addr_1     (ram_addr_1),
      .ram_port_en_0  (ram_port_en_0),
      .ram_port_en_1  (ram_port_en_1),
      .ram_data_out_0 (ram_data_out_0),
      .ram_data_out_1 (ram_data_out_1),
      .stall_cnt      (stall_cnt)
   );

   // 16x8 dual-address RAM: combinational reads, every enabled port written on wr_en
   logic [7:0] ram_mem [16];
   assign ram_data_out_0 = ram_mem[ram_addr_0];
   assign ram_data_out_1 = ram_mem[ram_addr_1];
   always @(posedge clk) begin
      if (ram_wr_en) begin
         if (ram_port_en_0) ram_mem[ram_addr_0] <= ram_data_in;
         if (ram_port_en_1) ram_mem[ram_addr_1] <= ram_data_in;
      end
   end

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] wdata;
   } req_t;

   req_t       q0[$], q1[$];
   logic [7:0] e0[$], e1[$];
   logic [7:0] mdl [16];
   bit         acc0, acc1, rr_m;
   int         exp_stall;
   int         total = 0;
   int         bad   = 0;

   function automatic req_t mk(input logic we, input logic [3:0] addr, input logic [7:0] wdata);
      req_t r;
      r.we = we;
      r.addr = addr;
      r.wdata = wdata;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard and reference model, sampled on the falling edge
   always @(negedge clk) begin
      logic xr0, xr1, anywr;
      acc0 = req0_valid & req0_ready;
      acc1 = req1_valid & req1_ready;
      if (rst_n) begin
         if (rsp0_valid) begin
            if (e0.size() == 0) check("rsp0_unexpected", 1, 0);
            else check("rsp0_rdata", rsp0_rdata, e0.pop_front());
         end
         if (rsp1_valid) begin
            if (e1.size() == 0) check("rsp1_unexpected", 1, 0);
            else check("rsp1_rdata", rsp1_rdata, e1.pop_front());
         end
         if (ram_wr_en) check("ram_wr_single_port", ram_port_en_0 ^ ram_port_en_1, 1);
         anywr = req0_we | req1_we;
         xr0 = req0_valid & (!req1_valid || !anywr || !rr_m);
         xr1 = req1_valid & (!req0_valid || !anywr || rr_m);
         check("ready0", req0_ready, xr0);
         check("ready1", req1_ready, xr1);
         if (acc0) begin
            if (req0_we) begin mdl[req0_addr] = req0_wdata; e0.push_back(req0_wdata); end
            else e0.push_back(mdl[req0_addr]);
         end
         if (acc1) begin
            if (req1_we) begin mdl[req1_addr] = req1_wdata; e1.push_back(req1_wdata); end
            else e1.push_back(mdl[req1_addr]);
         end
         exp_stall += int'(req0_valid & !xr0) + int'(req1_valid & !xr1);
         if (exp_stall > 255) exp_stall = 255;
         if (req0_valid && req1_valid && anywr) rr_m = !rr_m;
      end
   end

   // Request drivers: hold until accepted, then present the next queued request
   initial begin : drv
      req_t r;
      forever begin
         @(posedge clk);
         #1;
         if (!(req0_valid && !acc0)) begin
            if (q0.size() > 0) begin
               r = q0.pop_front();
               req0_valid = 1'b1; req0_we = r.we; req0_addr = r.addr; req0_wdata = r.wdata;
            end else req0_valid = 1'b0;
         end
         if (!(req1_valid && !acc1)) begin
            if (q1.size() > 0) begin
               r = q1.pop_front();
               req1_valid = 1'b1; req1_we = r.we; req1_addr = r.addr; req1_wdata = r.wdata;
            end else req1_valid = 1'b0;
         end
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid ||
              e0.size() > 0 || e1.size() > 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_within_budget", n < budget, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
      req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
      rr_m = 0; exp_stall = 0;

      // reset while both ports request conflicting writes
      q0.push_back(mk(1, 4'd3, 8'hA5));
      q1.push_back(mk(1, 4'd9, 8'h3C));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {req1_ready, req0_ready}, 0);
      check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      check("rst_rsp_rdata", {rsp1_rdata, rsp0_rdata}, 0);
      check("rst_ram_ctl", {ram_wr_en, ram_port_en_1, ram_port_en_0}, 0);
      check("rst_ram_bus", {ram_data_in, ram_addr_1, ram_addr_0}, 0);
      check("rst_stall", stall_cnt, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("first_grant_p0", req0_ready, 1);
      check("first_grant_p1", req1_ready, 0);
      @(negedge clk);
      @(negedge clk);
      check("wr_ram_wr_en", ram_wr_en, 1);
      check("wr_ram_port_en", {ram_port_en_1, ram_port_en_0}, 2'b01);
      check("wr_ram_data_in", ram_data_in, 8'hA5);
      check("wr_ram_addr_0", ram_addr_0, 4'd3);
      check("wr_stall_one", stall_cnt, 1);
      check("p1_granted_next", req1_ready, 1);
      wait_idle(50);
      check("stall_after_reset_test", stall_cnt, exp_stall);

      // parallel reads of the freshly written word
      q0.push_back(mk(0, 4'd3, 8'h00));
      q1.push_back(mk(0, 4'd3, 8'h00));
      wait_idle(50);

      // simultaneous writes, then cross read-back
      q0.push_back(mk(1, 4'd5, 8'h11));
      q1.push_back(mk(1, 4'd6, 8'h22));
      q0.push_back(mk(0, 4'd6, 8'h00));
      q1.push_back(mk(0, 4'd5, 8'h00));
      wait_idle(50);
      check("stall_after_dual_write", stall_cnt, exp_stall);

      // port 1 streams writes while port 0 streams reads of the same word
      for (int i = 0; i < 8; i++) begin
         q1.push_back(mk(1, 4'd7, 8'h40 + 8'(i)));
         q0.push_back(mk(0, 4'd7, 8'h00));
      end
      wait_idle(100);
      check("stall_after_stream", stall_cnt, exp_stall);

      // long forced conflict drives the counter into saturation
      for (int i = 0; i < 300; i++) begin
         q0.push_back(mk(1, 4'(i), 8'(i)));
         q1.push_back(mk(1, 4'(i + 8), ~8'(i)));
      end
      wait_idle(2000);
      check("stall_model_sat", exp_stall, 255);
      check("stall_saturated", stall_cnt, 8'hFF);

      // reset with a read in flight: it must produce no response
      q0.push_back(mk(0, 4'd5, 8'h00));
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_stall", stall_cnt, 0);
      check("rst_mid_cmd", {ram_port_en_1, ram_port_en_0, ram_wr_en}, 0);
      e0.delete(); e1.delete(); q0.delete(); q1.delete();
      rr_m = 0; exp_stall = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rsp_dropped", {rsp1_valid, rsp0_valid}, 0);
      q0.push_back(mk(0, 4'd5, 8'h00));
      q1.push_back(mk(0, 4'd12, 8'h00));
      wait_idle(50);
      check("stall_final", stall_cnt, exp_stall);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/dual_ram_access_ctrl.md
Name: dual_ram_access_ctrl

Overview:
Request/response front end that sits directly upstream of the 16x8 dual-address RAM and drives all of its pins.
- Two independent clients each issue read or write requests over a valid/ready handshake.
- The controller registers accepted requests into a command stage that drives the RAM.
- It returns captured read data, or a write acknowledge, per port one cycle later.
- It enforces the RAM's single-write-data constraint: any enabled port is written when wr_en is high, so a write cycle must enable exactly one port.

Parameters:
DATA_W, 8, data width; must match the RAM word.
ADDR_W, 4, address width; RAM depth is 2**ADDR_W.
STALL_W, 8, width of the saturating stall counter.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle
req0_we  in  1  port 0: 1 = write, 0 = read
req0_addr  in  ADDR_W  port 0 address
req0_wdata  in  DATA_W  port 0 write data
rsp0_valid  out  1  port 0 one-cycle response pulse
rsp0_rdata  out  DATA_W  port 0 read data, or echoed write data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  same as port 0, for port 1
ram_wr_en  out  1  to RAM wr_en
ram_data_in  out  DATA_W  to RAM data_in
ram_addr_0  out  ADDR_W  to RAM addr_in_0
ram_addr_1  out  ADDR_W  to RAM addr_in_1
ram_port_en_0  out  1  to RAM port_en_0
ram_port_en_1  out  1  to RAM port_en_1
ram_data_out_0  in  DATA_W  from RAM data_out_0 (combinational read)
ram_data_out_1  in  DATA_W  from RAM data_out_1
stall_cnt  out  STALL_W  saturating count of port-cycles with valid && !ready

Behaviour:
- Clocking: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset: all outputs 0, command stage empty, rr pointer = 0, stall_cnt = 0. Reset mid-operation drops in-flight commands; no response is produced for them.
- Grant logic is combinational from the req*_valid/req*_we inputs and the rr pointer; ready may depend on valid.
  - Only one port valid: grant it.
  - Both valid, both reads: grant both; rr unchanged.
  - Both valid, at least one write: grant only port rr; rr toggles at the clock edge.
- Requester holds valid/we/addr/wdata stable until ready; dropping valid before ready is illegal.
- Command stage: at edge N, granted requests are registered (en, we, addr, wdata per port). During cycle N+1 the stage drives the RAM.
  - Read cycle: ram_wr_en = 0; ram_port_en_x = en_x; ram_addr_x = addr_x.
  - Write cycle (exactly one en, we = 1): ram_wr_en = 1, only that port's ram_port_en set, ram_data_in = wdata; the RAM writes at edge N+1.
  - Idle: all RAM controls 0; ram_data_in = 0; unused ram_addr = 0.
- Response: at edge N+1, rspX_valid is set for one cycle for each port that had a command.
  - Read: rspX_rdata = ram_data_out_X sampled at edge N+1.
  - Write: rspX_rdata = written data.
  - rdata holds its value when valid = 0.
- Latency: accept edge to response = 1 cycle. Throughput = 1 request per port per cycle when there is no write conflict.
- Ordering: a write accepted at edge N is visible to a read accepted at edge N+1 or later. The command stage never mixes a write with a read, so a read-during-write hazard cannot occur.
- Same-port back-to-back requests are accepted every cycle; there is no response backpressure.
- stall_cnt: +1 per port per cycle that has valid && !ready (up to +2 per cycle); saturates at 2**STALL_W-1; never wraps.

Decomposition:
- Package dual_ram_pkg holds:
  - DATA_W/ADDR_W defaults;
  - cmd_t struct {en, we, addr, wdata};
  - rsp_t struct {valid, rdata}.
- Sub-module rr_arb2: 2-way round-robin arbiter with inputs req[1:0], conflict, and outputs gnt[1:0] plus the rr flop. Everything else stays in the top module.

Test Plan:
- Reset with both ports requesting: all outputs 0 and ready low while rst_n = 0; deasserting rst_n mid-cycle has no glitch effect; first grant goes to port 0.
- Port 0 writes 0xA5 to addr 3 (port 1 idle): ready the same cycle; next cycle ram_wr_en = 1, port_en_0 = 1, port_en_1 = 0, data_in = 0xA5; rsp0_valid pulse with rdata = 0xA5.
- Next cycle, port 0 reads addr 3 while port 1 reads addr 3: both granted; one cycle later both rsp_valid pulse with rdata = 0xA5.
- Both ports write (0x11 to addr 5, 0x22 to addr 6) in the same cycle with rr = 0: port 0 granted, port 1 stalls one cycle and stall_cnt becomes 1; then port 1 is granted. Read-back returns 0x11 and 0x22; RAM never sees both port_en with wr_en = 1.
- Port 1 writes continuously while port 0 reads continuously: grants alternate port 1, port 0, port 1, ...; each read returns data from all writes completed before its grant.
- 300 cycles of forced conflict with STALL_W = 8: stall_cnt saturates at 255 and stays there; a reset returns it to 0.
